cdb_request_queue: RTL and testbench

CDB_REQUEST_QUEUE -- requirements
Module: cdb_request_queue

---
 rtl/cdb_request_queue.sv | 135 +++++++++++++
 tb/tb_cdb_request_queue.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_request_queue.sv
// -----------------------------------------------------------------------------
// cdb_request_queue
//
// Holds completed functional-unit results until the common data bus (CDB)
// arbiter awards a broadcast slot. Results are stored in a circular FIFO and
// leave in arrival order.
//
// Handshake with the arbiter: cdb_req is raised in cycle t. A registered
// cdb_gnt in cycle t+1 awards a slot in that same cycle. The head entry is
// then driven combinationally onto out_* and popped at the end of the cycle.
// A flush (mispredict) squashes every held result and blocks any push,
// request or output in the flush cycle.
//
// Ports
//   clock      : clock
//   reset      : synchronous, active-high reset of pointers and occupancy
//   flush      : synchronous squash of all held results
//   in_valid   : FU presents a completed result
//   in_tag     : destination physical tag of the presented result
//   in_data    : result value
//   in_ready   : result is accepted this cycle (full queue accepts while popping)
//   cdb_req    : request for one CDB broadcast slot
//   cdb_gnt    : registered grant answering last cycle's cdb_req
//   out_valid  : head result is broadcast this cycle
//   out_tag    : broadcast tag (zero when out_valid is low)
//   out_data   : broadcast data (zero when out_valid is low)
//   count      : current occupancy
// -----------------------------------------------------------------------------
module cdb_request_queue #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic                     cdb_req,
  input  logic                     cdb_gnt,
  output logic                     out_valid,
  output logic [TAG_W-1:0]         out_tag,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  logic             push;
  logic             pop;
  logic [CNT_W-1:0] req_thresh;

  // ---------------------------------------------------------------------------
  // Combinational handshake and output path
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    out_valid  = 1'b0;
    out_tag    = '0;
    out_data   = '0;
    in_ready   = 1'b0;
    cdb_req    = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    req_thresh = '0;

    // A grant with an empty queue is a protocol error and is ignored.
    out_valid = cdb_gnt && (count != '0) && !flush;
    pop       = out_valid;

    // Only read storage when out_valid guarantees the head slot was written.
    if (out_valid) begin
      out_tag  = tag_mem[head];
      out_data = data_mem[head];
    end

    // A full queue can still accept because the head leaves this cycle.
    in_ready = (count < FULL_COUNT) || out_valid;
    push     = in_valid && in_ready && !flush;

    // In a granted cycle the head is already being served, so the request
    // must cover a second entry; otherwise it re-covers the current head.
    req_thresh = cdb_gnt ? CNT_W'(1) : '0;
    cdb_req    = (count > req_thresh) && !flush;
  end

  // ---------------------------------------------------------------------------
  // Pointer and occupancy state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      if (push) begin
        tail <= tail + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Entry storage
  // ---------------------------------------------------------------------------
  // NOTE: storage is deliberately left without reset; occupancy gates every
  // read, so stale contents are never observed and the array maps to plain RAM.
  always_ff @(posedge clock) begin
    if (push) begin
      tag_mem[tail]  <= in_tag;
      data_mem[tail] <= in_data;
    end
  end

endmodule

// File: tb/tb_cdb_request_queue.sv
// -----------------------------------------------------------------------------
// tb_cdb_request_queue
//
// Self-checking bench for cdb_request_queue. Directed scenarios from the
// block's behaviour description run first, followed by randomized traffic.
// Expected values come from a result queue that models the FIFO as a list
// of pending results, with the handshake rules applied on top.
// -----------------------------------------------------------------------------
module tb_cdb_request_queue;

  localparam int DEPTH  = 4;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic              clock;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic [TAG_W-1:0]  in_tag;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              cdb_req;
  logic              cdb_gnt;
  logic              out_valid;
  logic [TAG_W-1:0]  out_tag;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  count;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  entry_t model_q[$];
  bit     last_req;

  // Snapshot of the outputs observed in the most recent cycle.
  logic              s_in_ready;
  logic              s_cdb_req;
  logic              s_out_valid;
  logic [TAG_W-1:0]  s_out_tag;
  logic [DATA_W-1:0] s_out_data;
  logic [CNT_W-1:0]  s_count;

  cdb_request_queue #(
    .DEPTH  (DEPTH),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_tag    (in_tag),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .cdb_req   (cdb_req),
    .cdb_gnt   (cdb_gnt),
    .out_valid (out_valid),
    .out_tag   (out_tag),
    .out_data  (out_data),
    .count     (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Drives one clock cycle, checks every output against the model before the
  // edge, then advances the model across the edge.
  task automatic cycle(input string name, input bit v, input logic [TAG_W-1:0] t,
                       input logic [DATA_W-1:0] d, input bit g, input bit f, input bit r);
    bit                exp_ov;
    bit                exp_req;
    bit                exp_rdy;
    bit                do_push;
    logic [TAG_W-1:0]  exp_tag;
    logic [DATA_W-1:0] exp_data;
    entry_t            e;
    int                n;

    in_valid = v;
    in_tag   = t;
    in_data  = d;
    cdb_gnt  = g;
    flush    = f;
    reset    = r;
    #1;

    n        = model_q.size();
    exp_ov   = g && (n > 0) && !f;
    exp_req  = (n > (g ? 1 : 0)) && !f;
    exp_rdy  = (n < DEPTH) || exp_ov;
    exp_tag  = exp_ov ? model_q[0].tag  : '0;
    exp_data = exp_ov ? model_q[0].data : '0;
    do_push  = v && exp_rdy && !f;

    chk({name, ".out_valid"}, 64'(out_valid), 64'(exp_ov));
    chk({name, ".cdb_req"},   64'(cdb_req),   64'(exp_req));
    chk({name, ".in_ready"},  64'(in_ready),  64'(exp_rdy));
    chk({name, ".out_tag"},   64'(out_tag),   64'(exp_tag));
    chk({name, ".out_data"},  64'(out_data),  64'(exp_data));
    chk({name, ".count"},     64'(count),     64'(n));

    s_in_ready  = in_ready;
    s_cdb_req   = cdb_req;
    s_out_valid = out_valid;
    s_out_tag   = out_tag;
    s_out_data  = out_data;
    s_count     = count;

    @(posedge clock);
    if (r || f) begin
      model_q.delete();
    end else begin
      if (exp_ov) void'(model_q.pop_front());
      if (do_push) begin
        e.tag  = t;
        e.data = d;
        model_q.push_back(e);
      end
    end
    last_req = exp_req;
    #1;
  endtask

  task automatic idle(input string name, input bit g);
    cycle(name, 1'b0, '0, '0, g, 1'b0, 1'b0);
  endtask

  task automatic push_one(input string name, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    cycle(name, 1'b1, t, d, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit rv, rg, rf, rr;

    reset    = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_tag   = '0;
    in_data  = '0;
    cdb_gnt  = 1'b0;
    last_req = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state.
    idle("reset_state", 1'b0);
    chk("reset.in_ready", 64'(s_in_ready), 64'd1);
    chk("reset.count",    64'(s_count),    64'd0);

    // Single result: push, request, present, drained.
    push_one("single.push", 6'd5, 32'h11);
    idle("single.req", 1'b0);
    chk("single.req_high", 64'(s_cdb_req), 64'd1);
    idle("single.gnt", 1'b1);
    chk("single.out_valid", 64'(s_out_valid), 64'd1);
    chk("single.out_tag",   64'(s_out_tag),   64'd5);
    chk("single.out_data",  64'(s_out_data),  64'h11);
    idle("single.after", 1'b0);
    chk("single.count_after", 64'(s_count), 64'd0);

    // Arbitration loss: request held across three lost cycles.
    push_one("loss.push", 6'd7, 32'hBEEF);
    for (int i = 0; i < 3; i++) begin
      idle("loss.wait", 1'b0);
      chk("loss.req_held", 64'(s_cdb_req), 64'd1);
      chk("loss.no_out",   64'(s_out_valid), 64'd0);
    end
    idle("loss.gnt", 1'b1);
    chk("loss.out_tag", 64'(s_out_tag), 64'd7);
    chk("loss.count_before", 64'(s_count), 64'd1);
    idle("loss.after", 1'b0);
    chk("loss.count_after", 64'(s_count), 64'd0);

    // Full queue with simultaneous push and pop.
    for (int i = 1; i <= DEPTH; i++) begin
      push_one("full.fill", TAG_W'(i), DATA_W'(32'h100 + i));
    end
    idle("full.stall", 1'b0);
    chk("full.in_ready_low", 64'(s_in_ready), 64'd0);
    chk("full.count", 64'(s_count), 64'd4);
    cycle("full.swap", 1'b1, 6'd9, 32'h909, 1'b1, 1'b0, 1'b0);
    chk("full.swap_ready", 64'(s_in_ready), 64'd1);
    chk("full.swap_tag",   64'(s_out_tag),  64'd1);
    idle("full.drain0", 1'b1);
    chk("full.count_kept", 64'(s_count), 64'd4);
    chk("full.drain_tag2", 64'(s_out_tag), 64'd2);
    idle("full.drain1", 1'b1);
    chk("full.drain_tag3", 64'(s_out_tag), 64'd3);
    idle("full.drain2", 1'b1);
    chk("full.drain_tag4", 64'(s_out_tag), 64'd4);
    idle("full.drain3", 1'b1);
    chk("full.drain_tag9",  64'(s_out_tag),  64'd9);
    chk("full.drain_data9", 64'(s_out_data), 64'h909);
    idle("full.empty", 1'b0);

    // Pipelined requests: two entries granted back to back.
    push_one("pipe.push0", 6'hA, 32'hA0);
    push_one("pipe.push1", 6'hB, 32'hB0);
    idle("pipe.gnt0", 1'b1);
    chk("pipe.req_first", 64'(s_cdb_req), 64'd1);
    chk("pipe.tag_first", 64'(s_out_tag), 64'hA);
    idle("pipe.gnt1", 1'b1);
    chk("pipe.req_second", 64'(s_cdb_req), 64'd0);
    chk("pipe.tag_second", 64'(s_out_tag), 64'hB);
    chk("pipe.count_mid",  64'(s_count),   64'd1);
    idle("pipe.after", 1'b0);
    chk("pipe.count_after", 64'(s_count), 64'd0);

    // Flush with grant and push in the same cycle.
    for (int i = 0; i < 3; i++) push_one("flush.fill", TAG_W'(20 + i), DATA_W'(i));
    cycle("flush.cycle", 1'b1, 6'd30, 32'h30, 1'b1, 1'b1, 1'b0);
    chk("flush.no_out", 64'(s_out_valid), 64'd0);
    chk("flush.no_req", 64'(s_cdb_req),   64'd0);
    idle("flush.stray_gnt", 1'b1);
    chk("flush.count_zero", 64'(s_count), 64'd0);
    chk("flush.stray_out",  64'(s_out_valid), 64'd0);

    // Reset with a request outstanding, then a stray grant.
    for (int i = 0; i < 3; i++) push_one("rst.fill", TAG_W'(40 + i), DATA_W'(i));
    cycle("rst.cycle", 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("rst.req_before", 64'(s_cdb_req), 64'd1);
    idle("rst.stray_gnt", 1'b1);
    chk("rst.out_valid", 64'(s_out_valid), 64'd0);
    chk("rst.req",       64'(s_cdb_req),   64'd0);
    chk("rst.in_ready",  64'(s_in_ready),  64'd1);
    chk("rst.count",     64'(s_count),     64'd0);

    // Randomized traffic: grants mostly answer real requests, with occasional
    // stray grants, flushes and resets.
    for (int i = 0; i < 3000; i++) begin
      rv = ($urandom_range(99) < 60);
      rg = last_req ? ($urandom_range(99) < 70) : ($urandom_range(99) < 3);
      rf = ($urandom_range(99) < 3);
      rr = ($urandom_range(199) < 1);
      cycle("rand", rv, TAG_W'($urandom), DATA_W'($urandom), rg, rf, rr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
